// File: rtl/z80_bus_sampler.sv
// Z80 bus front end: synchronizes the active-low strobes, qualifies each bus
// cycle for FILT clocks and queues one {type, addr, data} event per cycle.
module z80_bus_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT        = 2,
  parameter int DEPTH       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mreq,
  input  logic        iorq,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] A,
  input  logic [7:0]  D,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [1:0]  ev_type,
  output logic [15:0] ev_addr,
  output logic [7:0]  ev_data,
  output logic        overflow,
  output logic [7:0]  drop_cnt,
  output logic        busy
);

  // state   | meaning
  // RELEASE | after reset, wait for mreq and iorq both high
  // IDLE    | bus quiet, watching for a classification
  // QUAL    | classification seen, counting to FILT
  // ACTIVE  | event pushed, wait for strobes to release
  typedef enum logic [1:0] {S_RELEASE, S_IDLE, S_QUAL, S_ACTIVE} state_t;

  localparam int CW = (FILT < 2) ? 1 : $clog2(FILT + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] r_mreq_sync;
  logic [SYNC_STAGES-1:0] r_iorq_sync;
  logic [SYNC_STAGES-1:0] r_rd_sync;
  logic [SYNC_STAGES-1:0] r_wr_sync;

  logic       w_mreq_s;
  logic       w_iorq_s;
  logic       w_rd_s;
  logic       w_wr_s;
  logic       w_bus_idle;
  logic       w_cls_none;
  logic [1:0] w_cls;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_cls;
  logic          r_busy;
  logic          w_push;

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   w_rd_nxt;
  logic [25:0]   r_mem [DEPTH];
  logic [25:0]   r_head;
  logic [25:0]   w_word;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_drop;
  logic          r_overflow;
  logic [7:0]    r_drop_cnt;

  // Synchronizers keep sampling through reset so RELEASE sees the true bus.
  always_ff @(posedge clk) begin
    r_mreq_sync <= {r_mreq_sync[SYNC_STAGES-2:0], mreq};
    r_iorq_sync <= {r_iorq_sync[SYNC_STAGES-2:0], iorq};
    r_rd_sync   <= {r_rd_sync[SYNC_STAGES-2:0], rd};
    r_wr_sync   <= {r_wr_sync[SYNC_STAGES-2:0], wr};
  end

  assign w_mreq_s   = r_mreq_sync[SYNC_STAGES-1];
  assign w_iorq_s   = r_iorq_sync[SYNC_STAGES-1];
  assign w_rd_s     = r_rd_sync[SYNC_STAGES-1];
  assign w_wr_s     = r_wr_sync[SYNC_STAGES-1];
  assign w_bus_idle = w_mreq_s & w_iorq_s;

  always_comb begin
    w_cls_none = 1'b1;
    w_cls      = 2'b00;
    if (!w_mreq_s && w_iorq_s) begin
      if (!w_rd_s && w_wr_s) begin
        w_cls_none = 1'b0;
        w_cls      = 2'b00;
      end else if (w_rd_s && !w_wr_s) begin
        w_cls_none = 1'b0;
        w_cls      = 2'b01;
      end
    end else if (w_mreq_s && !w_iorq_s) begin
      if (!w_rd_s && w_wr_s) begin
        w_cls_none = 1'b0;
        w_cls      = 2'b10;
      end else if (w_rd_s && !w_wr_s) begin
        w_cls_none = 1'b0;
        w_cls      = 2'b11;
      end
    end
  end

  always_comb begin
    w_push = 1'b0;
    case (r_state)
      S_IDLE:  w_push = !w_cls_none && (FILT == 1);
      S_QUAL:  w_push = !w_cls_none && (w_cls == r_cls) &&
                        ((r_cnt + CW'(1)) == CW'(FILT));
      default: w_push = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RELEASE;
      r_cnt   <= '0;
      r_cls   <= 2'b00;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        S_RELEASE: begin
          if (w_bus_idle) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (!w_cls_none) begin
            r_cls   <= w_cls;
            r_cnt   <= CW'(1);
            r_busy  <= 1'b1;
            r_state <= (FILT == 1) ? S_ACTIVE : S_QUAL;
          end
        end
        S_QUAL: begin
          if (w_cls_none || (w_cls != r_cls)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_push) begin
            r_state <= S_ACTIVE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_ACTIVE: begin
          if (w_bus_idle) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_RELEASE;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign w_word    = {w_cls, A, D};
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop     = !w_empty && ev_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;
  assign w_rd_nxt  = r_rd_ptr + {{AW{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_word;
    end
  end

  // Head register: fall-through on push into an empty queue, else next entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_head     <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      r_rd_ptr <= w_rd_nxt;
      if (w_push_ok && (w_rd_nxt == r_wr_ptr)) begin
        r_head <= w_word;
      end else if (w_rd_nxt != r_wr_ptr) begin
        r_head <= r_mem[w_rd_nxt[AW-1:0]];
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  assign ev_valid = !w_empty;
  assign ev_type  = r_head[25:24];
  assign ev_addr  = r_head[23:8];
  assign ev_data  = r_head[7:0];
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;
  assign busy     = r_busy;

endmodule

// File: tb/tb_z80_bus_sampler.sv
// Directed bench for z80_bus_sampler: an event-level model (strobe history,
// run length, queue) is compared every cycle, plus literal checks.
module tb_z80_bus_sampler;

  localparam int S   = 2;
  localparam int F   = 2;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mreq = 1'b1, iorq = 1'b1, rd = 1'b1, wr = 1'b1;
  logic [15:0] A = 16'h0000;
  logic [7:0]  D = 8'h00;
  logic        ev_ready = 1'b0;
  logic        ev_valid;
  logic [1:0]  ev_type;
  logic [15:0] ev_addr;
  logic [7:0]  ev_data;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        busy;

  int n_cmp = 0;
  int n_fail = 0;

  z80_bus_sampler #(.SYNC_STAGES(S), .FILT(F), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr),
    .A(A), .D(D), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type),
    .ev_addr(ev_addr), .ev_data(ev_data), .overflow(overflow),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: {none, type} of a raw strobe set, from the bus-cycle table.
  function automatic logic [2:0] classify(input logic m, input logic i,
                                          input logic r, input logic w);
    if (!m && i && !r && w) return 3'b000;
    if (!m && i && r && !w) return 3'b001;
    if (m && !i && !r && w) return 3'b010;
    if (m && !i && r && !w) return 3'b011;
    return 3'b100;
  endfunction

  logic [2:0]  m_dcls [S];
  bit          m_didle [S];
  logic [2:0]  m_prev = 3'b100;
  logic [2:0]  m_s;
  bit          m_sidle;
  int          m_run = 0;
  bit          m_armed = 0;
  bit          m_push;
  bit          m_init = 0;
  logic [25:0] m_q [$];
  logic [25:0] m_head = '0;
  bit          m_ovf = 0;
  int          m_drop = 0;

  initial begin
    for (int i = 0; i < S; i++) begin
      m_dcls[i] = 3'b100;
      m_didle[i] = 1'b1;
    end
  end

  always @(posedge clk) begin
    m_s = m_dcls[S-1];
    m_sidle = m_didle[S-1];
    for (int i = S - 1; i > 0; i--) begin
      m_dcls[i] = m_dcls[i-1];
      m_didle[i] = m_didle[i-1];
    end
    m_dcls[0] = classify(mreq, iorq, rd, wr);
    m_didle[0] = mreq && iorq;
    if (reset) begin
      m_init = 1;
      m_armed = 0;
      m_run = 0;
      m_prev = 3'b100;
      m_q.delete();
      m_head = '0;
      m_ovf = 0;
      m_drop = 0;
    end else begin
      if (m_s[2]) m_run = 0;
      else if (m_s == m_prev) m_run = m_run + 1;
      else m_run = 1;
      m_prev = m_s;
      m_push = m_armed && !m_s[2] && (m_run == F);
      if (m_push) m_armed = 0;
      if (m_sidle) m_armed = 1;
      if (m_q.size() > 0 && ev_ready) void'(m_q.pop_front());
      if (m_push) begin
        if (m_q.size() < DEP) m_q.push_back({m_s[1:0], A, D});
        else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop = m_drop + 1;
        end
      end
      if (m_q.size() > 0) m_head = m_q[0];
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    logic [35:0] act, exp_v;
    if (m_init) begin
      act = {ev_valid, ev_type, ev_addr, ev_data, overflow, drop_cnt};
      exp_v = {(m_q.size() > 0), m_head, m_ovf, 8'(m_drop)};
      n_cmp++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL model_cycle t=%0t: got %h expected %h", $time, act, exp_v);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_count(input int n, output int nval);
    nval = 0;
    repeat (n) begin
      @(negedge clk);
      if (ev_valid) nval++;
    end
  endtask

  task automatic start_cycle(input bit io, input bit is_wr, input logic [15:0] a,
                             input logic [7:0] d);
    A = a;
    D = d;
    mreq = io;
    iorq = !io;
    rd = is_wr;
    wr = !is_wr;
  endtask

  task automatic end_cycle();
    mreq = 1'b1;
    iorq = 1'b1;
    rd = 1'b1;
    wr = 1'b1;
  endtask

  initial begin
    int p, p2;
    // Reset: 3 clocks with strobes high
    tick(3);
    check("rst_valid", ev_valid, 0);
    check("rst_out", {ev_type, ev_addr, ev_data}, 0);
    check("rst_ovf_drop", {overflow, drop_cnt}, 0);
    check("rst_busy", busy, 1);
    reset = 1'b0;
    tick(1);
    check("busy_after_release", busy, 0);
    tick(2);

    // IO write to 0x7FFD
    ev_ready = 1'b1;
    start_cycle(1, 1, 16'h7FFD, 8'h55);
    tick(3);
    check("io_wr_pre_latency", ev_valid, 0);
    tick(1);
    check("io_wr_valid", ev_valid, 1);
    check("io_wr_type", ev_type, 2'b11);
    check("io_wr_addr", ev_addr, 16'h7FFD);
    check("io_wr_data", ev_data, 8'h55);
    check("io_wr_busy", busy, 1);
    run_count(16, p);
    check("io_wr_single", p + 1, 1);
    end_cycle();
    tick(4);

    // Glitch, refresh, interrupt acknowledge
    start_cycle(1, 1, 16'h1234, 8'hAA);
    tick(1);
    end_cycle();
    run_count(6, p);
    check("glitch_no_event", p, 0);
    mreq = 1'b0;
    run_count(8, p);
    mreq = 1'b1;
    run_count(4, p2);
    check("refresh_no_event", p + p2, 0);
    iorq = 1'b0;
    run_count(8, p);
    iorq = 1'b1;
    run_count(4, p2);
    check("intack_no_event", p + p2, 0);

    // Overflow: 5 writes into a 4-deep FIFO with no consumer
    ev_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      start_cycle(1, 1, 16'h7FFD, 8'(i));
      tick(5);
      end_cycle();
      tick(3);
    end
    check("ovf_flag", overflow, 1);
    check("ovf_drop_cnt", drop_cnt, 1);
    ev_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("ovf_drain_valid", ev_valid, 1);
      check("ovf_drain_data", ev_data, i);
      tick(1);
    end
    check("ovf_drained", ev_valid, 0);
    check("ovf_hold_last", {ev_addr, ev_data}, {16'h7FFD, 8'h04});

    // Full FIFO, 5th push coincides with a pop
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start_cycle(1, 1, 16'h7FFD, 8'(8'h11 + i));
      tick(5);
      end_cycle();
      tick(3);
    end
    start_cycle(1, 1, 16'h7FFD, 8'h15);
    tick(3);
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    check("full_pop_no_ovf", {overflow, drop_cnt}, 0);
    check("full_pop_head", ev_data, 8'h12);
    tick(2);
    end_cycle();
    tick(3);
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("full_pop_drain", {ev_valid, ev_data}, {1'b1, 8'(8'h12 + i)});
      tick(1);
    end
    check("full_pop_empty", ev_valid, 0);

    // Reset in the middle of an IO write
    ev_ready = 1'b0;
    start_cycle(1, 1, 16'h00FD, 8'hEE);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    run_count(10, p);
    check("rst_mid_no_event", p, 0);
    check("rst_mid_release_busy", busy, 1);
    end_cycle();
    tick(3);
    check("rst_mid_idle", busy, 0);
    start_cycle(0, 0, 16'h0000, 8'hFF);
    tick(4);
    check("mem_rd_event", {ev_valid, ev_type, ev_addr, ev_data}, {1'b1, 2'b00, 16'h0000, 8'hFF});
    tick(2);
    end_cycle();
    tick(3);
    ev_ready = 1'b1;
    tick(1);
    check("mem_rd_single", ev_valid, 0);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/z80_bus_sampler.md
# z80_bus_sampler

Clocked front end for the Z80 bus on the debug board. It synchronizes and qualifies the CPU's asynchronous active-low strobes, then classifies each bus cycle. It captures the address and data of every cycle, including port 0x7FFD paging writes, and queues one event per cycle in a small FIFO. The downstream decode/paging stage consumes the FIFO through a valid/ready handshake, so it always sees clean, single-shot, glitch-free bus events.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth for mreq/iorq/rd/wr (≥2)
- FILT, 2, consecutive clocks a classification must hold before it is accepted (≥1)
- DEPTH, 4, event FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  system clock; must be ≥4× CPU clock
- reset  in  1  synchronous, active-high
- mreq  in  1  Z80 MREQ, active-low, async
- iorq  in  1  Z80 IORQ, active-low, async
- rd  in  1  Z80 RD, active-low, async
- wr  in  1  Z80 WR, active-low, async
- A  in  16  Z80 address bus
- D  in  8  Z80 data bus (observe only, never driven)
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts head this clock
- ev_type  out  2  00 mem rd, 01 mem wr, 10 io rd, 11 io wr
- ev_addr  out  16  captured address
- ev_data  out  8  captured data
- overflow  out  1  sticky: ≥1 event dropped since reset
- drop_cnt  out  8  dropped events, saturates at 255
- busy  out  1  FSM not in IDLE

## Operation
- Strobes pass through SYNC_STAGES flops. A and D are sampled raw; the CPU holds them stable while the strobe is asserted.
- Classification from the synced strobes:
  - mreq&rd → mem rd; mreq&wr → mem wr; iorq&rd → io rd; iorq&wr → io wr.
  - Any other combination is "none". This covers refresh (mreq without rd/wr), interrupt acknowledge (iorq without rd/wr) and idle.
- FSM states: RELEASE, IDLE, QUAL, ACTIVE.
  - RELEASE: entered on reset. Waits until synced mreq and iorq are both high, then goes to IDLE.
  - IDLE: a classification other than none loads the count with 1 and goes to QUAL (direct to push if FILT=1).
  - QUAL: if the classification is unchanged, count increments. When count reaches FILT, capture A and D, push the event, and go to ACTIVE. If the classification changes or becomes none, return to IDLE with no event.
  - ACTIVE: holds until synced mreq and iorq are both high, then goes to IDLE. This gives exactly one event per strobe assertion, however long the strobe is held.
- FIFO:
  - First-word fall-through. The head is presented on ev_type/addr/data.
  - Pop occurs when ev_valid&ev_ready.
  - Outputs stay stable while ev_valid&!ev_ready.
- Full FIFO on push:
  - If a pop happens in the same clock, the push is accepted.
  - Otherwise the event is dropped, overflow is set, and drop_cnt increments (saturating at 255).
- Push and pop in the same clock on a non-empty FIFO leave the occupancy unchanged.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.

## Timing
- Reset values: ev_valid=0, ev_type=0, ev_addr=0, ev_data=0, overflow=0, drop_cnt=0, busy=1 (RELEASE). The FIFO is emptied.
- Reset mid-cycle:
  - The cycle in progress is discarded.
  - Because of RELEASE, a strobe still low when reset deasserts produces no event.
- Latency:
  - Let edge 0 be the first rising edge that samples a qualifying strobe combination.
  - The push occurs at edge SYNC_STAGES+FILT−1.
  - With an empty FIFO, ev_valid goes high after edge SYNC_STAGES+FILT−1: 3 clocks with the defaults.
- A strobe shorter than SYNC_STAGES+FILT−1 clocks at the synchronizer input may be lost. Shorter glitches never produce an event.
- After a pop, the next entry is visible on the following clock. Throughput is one event per clock.
- The output registers hold their last value when the FIFO is empty.

## Test plan
- Reset: hold reset 3 clocks with strobes high → all outputs at their reset values; busy falls 1 clock after release.
- IO write: A=0x7FFD, D=0x55, wr=0, iorq=0 for 20 clocks, ev_ready=1 → exactly one event, type=11, addr=0x7FFD, data=0x55; ev_valid high 3 clocks after first sample.
- Glitch/ignored cycles:
  - iorq low for 1 clock → no event.
  - mreq low with rd=wr=1 (refresh) → no event.
  - iorq low with rd=wr=1 (int ack) → no event.
- Overflow: ev_ready=0, 5 io writes to 0x7FFD with D=0x01..0x05 → overflow=1, drop_cnt=1. Then ev_ready=1 → 01, 02, 03, 04 delivered in order on consecutive clocks.
- Full with simultaneous pop: FIFO full, 5th push on the same clock as a pop → no drop, overflow stays 0.
- Reset mid-cycle: iorq=wr=0 (A=0x00FD, D=0xEE), pulse reset, keep strobes low 10 more clocks → no event. Then release and perform a mem read at 0x0000 with D=0xFF → one event, type=00, addr=0x0000, data=0xFF.
